// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the MCP4911-style DAC serialiser: frame layout,
// FSM state encoding and the frame-word builder.
package dac_spi_tx_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CFG_MSB    = 15;
    localparam int unsigned DATA_MSB   = 11;
    localparam int unsigned DATA_LSB   = 2;
    localparam int unsigned DATA_BITS  = DATA_MSB - DATA_LSB + 1;
    localparam int unsigned CNT_BITS   = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LATCH
    } state_e;

    // Word = {write-DACA, BUF, GA_n, SHDN_n, data[9:0], 2'b00}
    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [DATA_BITS-1:0] data,
        input logic                 vref_buf,
        input logic                 ga_n,
        input logic                 shdn_n
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[CFG_MSB]           = 1'b0;
        f[CFG_MSB-1]         = vref_buf;
        f[CFG_MSB-2]         = ga_n;
        f[CFG_MSB-3]         = shdn_n;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample-in / SPI-out bundle for dac_spi_tx; slave is the serialiser side.
interface dac_spi_tx_if
    import dac_spi_tx_pkg::*;
;
    logic                 sample_strobe;
    logic [DATA_BITS-1:0] data_in;
    logic                 dac_sck;
    logic                 dac_sdi;
    logic                 dac_cs_n;
    logic                 dac_ld_n;
    logic                 busy;
    logic                 overrun;

    modport master (
        output sample_strobe, data_in,
        input  dac_sck, dac_sdi, dac_cs_n, dac_ld_n, busy, overrun
    );

    modport slave (
        input  sample_strobe, data_in,
        output dac_sck, dac_sdi, dac_cs_n, dac_ld_n, busy, overrun
    );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled, held at 0
// while disabled so every frame starts on a fresh half-period.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk) begin
        if (!reset_n || !en) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        tick = en && (cnt == TERM);
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 10-bit samples to an MCP4911-style SPI DAC with a one-deep
// pending slot and sticky overrun flag.
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16,
    parameter logic        BUF     = 1'b0,
    parameter logic        GA_N    = 1'b1,
    parameter logic        SHDN_N  = 1'b1
) (
    input  logic         sysclk,
    input  logic         reset_n,
    dac_spi_tx_if.slave  bus
);

    state_e                state, state_nx;
    logic [FRAME_BITS-1:0] shift_reg, shift_nx;
    logic [CNT_BITS-1:0]   bit_cnt, bit_cnt_nx;
    logic                  sck_hi, sck_hi_nx;
    logic [DATA_BITS-1:0]  pend_data, pend_data_nx;
    logic                  pend_valid, pend_valid_nx;
    logic                  overrun_q, overrun_nx;
    logic                  consume;
    logic                  tick;
    logic                  sck_q, sdi_q, cs_n_q, ld_n_q, busy_q;
    logic                  sck_nx, sdi_nx, cs_n_nx, ld_n_nx, busy_nx;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .en      (state != IDLE),
        .tick    (tick)
    );

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            sck_hi     <= 1'b0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            overrun_q  <= 1'b0;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            ld_n_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            bit_cnt    <= bit_cnt_nx;
            sck_hi     <= sck_hi_nx;
            pend_data  <= pend_data_nx;
            pend_valid <= pend_valid_nx;
            overrun_q  <= overrun_nx;
            sck_q      <= sck_nx;
            sdi_q      <= sdi_nx;
            cs_n_q     <= cs_n_nx;
            ld_n_q     <= ld_n_nx;
            busy_q     <= busy_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shift_nx   = shift_reg;
        bit_cnt_nx = bit_cnt;
        sck_hi_nx  = sck_hi;
        consume    = 1'b0;

        case (state)
            IDLE: begin
                if (pend_valid) begin
                    consume   = 1'b1;
                    shift_nx  = make_frame(pend_data, BUF, GA_N, SHDN_N);
                    sck_hi_nx = 1'b0;
                    state_nx  = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    bit_cnt_nx = CNT_BITS'(FRAME_BITS - 1);
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sck_hi) begin
                        sck_hi_nx = 1'b1;
                    end else begin
                        sck_hi_nx = 1'b0;
                        if (bit_cnt == '0) begin
                            state_nx = HOLD;
                        end else begin
                            shift_nx   = {shift_reg[FRAME_BITS-2:0], 1'b0};
                            bit_cnt_nx = bit_cnt - 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) state_nx = LATCH;
            end
            LATCH: begin
                if (tick) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // A strobe coinciding with a consume refills the slot without overrun
        pend_data_nx  = pend_data;
        pend_valid_nx = pend_valid;
        overrun_nx    = overrun_q;
        if (bus.sample_strobe) begin
            pend_data_nx  = bus.data_in;
            pend_valid_nx = 1'b1;
            if (pend_valid && !consume) overrun_nx = 1'b1;
        end else if (consume) begin
            pend_valid_nx = 1'b0;
        end

        // Pins are decoded from the next state so they register alongside it
        sck_nx  = (state_nx == SHIFT) && sck_hi_nx;
        cs_n_nx = !((state_nx == SETUP) || (state_nx == SHIFT) || (state_nx == HOLD));
        ld_n_nx = (state_nx != LATCH);
        busy_nx = (state_nx != IDLE);
        sdi_nx  = ((state_nx == SETUP) || (state_nx == SHIFT)) ? shift_nx[FRAME_BITS-1] : 1'b0;
    end

    assign bus.dac_sck  = sck_q;
    assign bus.dac_sdi  = sdi_q;
    assign bus.dac_cs_n = cs_n_q;
    assign bus.dac_ld_n = ld_n_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: stimulus queues expected frame words, an
// SPI monitor reassembles each frame and checks word, bit count and timing.
module tb_dac_spi_tx;

    logic sysclk;
    logic reset_n;

    dac_spi_tx_if bus ();

    dac_spi_tx #(
        .CLK_DIV (16),
        .BUF     (1'b0),
        .GA_N    (1'b1),
        .SHDN_N  (1'b1)
    ) dut (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [15:0] sb_q[$];

    // ---------------- SPI monitor ----------------
    int          mstate = 0;
    logic [15:0] cap;
    int          nbits = 0;
    int          cs_cnt, busy_cnt, ld_cnt;
    logic        prev_sck, held_sdi, sdi_bad;
    int          frames_done = 0;
    int          aborts = 0;
    int          end_cyc = -100;
    int          last_gap = -1;

    always @(negedge sysclk) begin
        if (!reset_n) begin
            if (mstate != 0) aborts++;
            mstate   = 0;
            prev_sck = 1'b0;
        end else begin
            if (mstate == 0 && bus.dac_cs_n == 1'b0) begin
                mstate   = 1;
                cap      = '0;
                nbits    = 0;
                cs_cnt   = 0;
                busy_cnt = 0;
                ld_cnt   = 0;
                sdi_bad  = 1'b0;
                prev_sck = 1'b0;
                held_sdi = 1'b0;
                last_gap = cyc - end_cyc;
            end
            if (mstate == 1) begin
                if (bus.dac_cs_n == 1'b0) begin
                    cs_cnt++;
                    if (bus.busy) busy_cnt++;
                    if (bus.dac_sck && !prev_sck) begin
                        cap      = {cap[14:0], bus.dac_sdi};
                        nbits++;
                        held_sdi = bus.dac_sdi;
                    end else if (bus.dac_sck && bus.dac_sdi != held_sdi) begin
                        sdi_bad = 1'b1;
                    end
                    prev_sck = bus.dac_sck;
                end else begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", int'(cap), -1);
                    end else begin
                        check("frame_word", int'(cap), int'(sb_q.pop_front()));
                    end
                    check("sck_rising_edges", nbits, 16);
                    check("cs_low_cycles", cs_cnt, 544);
                    check("sdi_stable_sck_high", int'(sdi_bad), 0);
                    mstate = 2;
                end
            end
            if (mstate == 2) begin
                if (bus.busy) begin
                    busy_cnt++;
                    if (!bus.dac_ld_n) ld_cnt++;
                end else begin
                    check("ld_pulse_cycles", ld_cnt, 16);
                    check("busy_cycles", busy_cnt, 560);
                    frames_done++;
                    end_cyc = cyc;
                    mstate  = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic strobe(input logic [9:0] d);
        @(posedge sysclk); #2;
        bus.sample_strobe = 1'b1;
        bus.data_in       = d;
        @(posedge sysclk); #2;
        bus.sample_strobe = 1'b0;
        bus.data_in       = 10'h2C3;  // ignored between strobes
    endtask

    task automatic send(input logic [9:0] d, input logic [15:0] exp);
        sb_q.push_back(exp);
        strobe(d);
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 3000) begin
            @(posedge sysclk);
            k++;
        end
        check("frames_completed", frames_done, n);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge sysclk);
    endtask

    task automatic check_idle_pins(input string tag, input int exp_overrun);
        check({tag, "_cs_n"}, int'(bus.dac_cs_n), 1);
        check({tag, "_ld_n"}, int'(bus.dac_ld_n), 1);
        check({tag, "_sck"}, int'(bus.dac_sck), 0);
        check({tag, "_sdi"}, int'(bus.dac_sdi), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_overrun"}, int'(bus.overrun), exp_overrun);
    endtask

    initial begin
        int k;
        int bad;
        reset_n           = 1'b0;
        bus.sample_strobe = 1'b0;
        bus.data_in       = '0;

        // Strobe while held in reset must not survive release
        idle_cycles(2);
        strobe(10'h3FF);
        @(negedge sysclk);
        check_idle_pins("reset", 0);
        @(posedge sysclk); #2;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sysclk);
            if (bus.busy || !bus.dac_cs_n) bad++;
        end
        check("no_frame_after_reset", bad, 0);

        // Single frames
        send(10'h3FF, 16'h3FFC);
        wait_frames(1);
        send(10'h200, 16'h3800);
        wait_frames(2);
        send(10'h155, 16'h3554);
        wait_frames(3);

        // Queued sample goes out back-to-back
        send(10'h100, 16'h3400);
        idle_cycles(100);
        send(10'h0AA, 16'h32A8);
        wait_frames(5);
        check("back_to_back_gap", last_gap, 1);
        @(negedge sysclk);
        check("overrun_after_queue", int'(bus.overrun), 0);

        // Overrun: second strobe while slot is full wins
        send(10'h3C0, 16'h3F00);
        idle_cycles(50);
        strobe(10'h001);
        idle_cycles(10);
        send(10'h002, 16'h3008);
        wait_frames(7);
        @(negedge sysclk);
        check("overrun_set", int'(bus.overrun), 1);
        send(10'h000, 16'h3000);
        wait_frames(8);
        @(negedge sysclk);
        check("overrun_sticky", int'(bus.overrun), 1);

        // Reset during bit 7 with a sample pending
        send(10'h3FF, 16'h3FFC);
        idle_cycles(30);
        strobe(10'h123);
        k = 0;
        while (nbits < 9 && k < 1000) begin
            @(posedge sysclk);
            k++;
        end
        check("reached_bit7", nbits, 9);
        #2;
        reset_n = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        check_idle_pins("abort", 0);
        sb_q.delete();
        idle_cycles(2); #2;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            if (bus.busy || !bus.dac_ld_n || !bus.dac_cs_n) bad++;
        end
        check("no_frame_after_abort", bad, 0);
        check("abort_count", aborts, 1);

        send(10'h2AB, 16'h3AAC);
        wait_frames(9);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
